serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes D = A - B - Bin over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow.
- Area-lean counterpart to the team's combinational ripple-carry adder, for datapaths where latency is cheaper than a WIDTH-bit carry chain.
- Sits behind a start/done handshake driven by a controller FSM.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; latched on accepted start
- B  input  WIDTH  subtrahend; latched on accepted start
- Bin  input  1  borrow-in; latched on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when D/Bout become valid
- D  output  WIDTH  difference, (A - B - Bin) mod 2^WIDTH
- Bout  output  1  borrow-out; 1 iff A < B + Bin, unsigned

Behaviour:
- One clock. Reset is synchronous and active-high; port names are clk and rst.
- Reset values: busy=0, done=0, D=0, Bout=0. Internal state returns to IDLE, counter=0, borrow=0.
- FSM states are IDLE, RUN and DONE.
- IDLE to RUN: on the edge where start=1.
  - Latch A, B and Bin into shift registers a_sr, b_sr and borrow.
  - Clear the result shift register and the counter.
- RUN, each edge:
  - Compute d = a0 ^ b0 ^ br.
  - Compute br' = (~a0 & b0) | (~a0 & br) | (b0 & br).
  - Shift d into the result MSB and shift the result right.
  - Shift a_sr and b_sr right; increment the counter.
- RUN to DONE: on the edge that processes bit WIDTH-1.
  - D receives the full result and Bout receives the final borrow on this same edge.
- DONE to IDLE: unconditionally on the next edge. done=1 only during the DONE cycle.
- Latency: start sampled at edge k; busy=1 from edge k+1 through edge k+WIDTH; done=1 for the one cycle following edge k+WIDTH.
- busy is a registered output: busy=1 exactly while the state is RUN.
- D and Bout hold their last result until the next completion or reset. They do not change during RUN.
- Operand inputs may change freely after the accepting edge without affecting the result.
- start while in RUN or DONE is ignored. No queuing; the requester must wait for IDLE (busy=0 and done=0).
- start held high continuously: a new operation is accepted on each IDLE cycle, giving a back-to-back period of WIDTH+2 cycles.
- rst asserted in any state: abort on that edge and apply reset values. A partial result is never presented and done does not pulse.
- rst and start asserted together: rst wins.
- Wrap-around: a negative result wraps modulo 2^WIDTH and Bout=1.
  - Example: A=0, B=0, Bin=1 gives D=all ones, Bout=1.

Decomposition:
- Package serial_sub_pkg contains:
  - typedef enum logic [1:0] sub_state_t {IDLE, RUN, DONE};
  - function clog2_w returning the counter width, $clog2(WIDTH).
- One sub-module, full_subtractor_bit, with ports a, b, bin -> d, bout (combinational cell).
  - Instantiated once in serial_subtractor.
  - Mirrors the adder's full-adder cell and is reusable in a future ripple-borrow subtractor.

Test Plan (WIDTH=4):
- A=1000, B=0001, Bin=1, start one cycle -> busy high 4 cycles; done pulse 1 cycle; D=0110, Bout=0.
- A=0001, B=1111, Bin=0 -> D=0010, Bout=1 (wrap).
- A=1101, B=0011, Bin=0; A/B driven to random values during RUN -> D=1010, Bout=0 (latched operands used).
- A=0000, B=0000, Bin=1 -> D=1111, Bout=1; then start re-asserted during RUN and DONE -> ignored; busy/done timing unchanged.
- rst asserted on the 2nd RUN edge of A=0111, B=0010 -> next cycle busy=0, done=0, D=0000, Bout=0; no done pulse follows. A fresh start with A=0111, B=0010, Bin=0 then gives D=0101, Bout=0.
- Exhaustive sweep of all 512 (A, B, Bin) combinations with start held high -> each result matches a reference model; done period is exactly 6 cycles.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the controller state encoding and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bits needed to count bit positions 0..width-1.
    function automatic int clog2_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
// Combinational counterpart of the adder's full-adder cell.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin over WIDTH cycles, LSB first,
// one full-subtractor cell plus a registered borrow, behind start/done.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int            CW   = clog2_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == LAST);
    assign res_next = {cell_d, res_sr[WIDTH-1:1]};

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // busy/done are decoded from the next state so they are true flop outputs
    // that line up exactly with RUN and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        borrow <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= cell_bout;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        D    <= res_next;
                        Bout <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
